// File: rtl/user_pulse_sequencer.sv
// Command-queue driven OBI manager that replays configure/start/wait/delay
// sequences onto the 4-channel pulser wrapper register map.

package user_pulse_sequencer_pkg;

   typedef struct packed {
      int unsigned addr_width;
      int unsigned data_width;
      int unsigned id_width;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{addr_width: 32, data_width: 32, id_width: 1};

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [0:0]  aid;
   } obi_a_chan_t;

   typedef struct packed {
      logic        req;
      obi_a_chan_t a;
   } obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
   } obi_r_chan_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      obi_r_chan_t r;
   } obi_rsp_t;

endpackage

// state | meaning
// IDLE  | pop and dispatch the next queued command
// REQ   | OBI request held until granted
// RESP  | waiting for rvalid; WAIT_READY decides re-poll here
// DELAY | counting down the idle cycles of a DELAY command
module user_pulse_sequencer #(
   parameter user_pulse_sequencer_pkg::obi_cfg_t ObiCfg = user_pulse_sequencer_pkg::ObiDefaultConfig,
   parameter type obi_req_t = user_pulse_sequencer_pkg::obi_req_t,
   parameter type obi_rsp_t = user_pulse_sequencer_pkg::obi_rsp_t,
   parameter logic [31:0] BaseAddr = 32'h0,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [2:0]               cmd_op_i,
   input  logic [1:0]               cmd_sel_i,
   input  logic [31:0]              cmd_data_i,
   input  logic                     flush_i,
   input  logic                     clr_i,
   output obi_req_t                 obi_req_o,
   input  obi_rsp_t                 obi_rsp_i,
   output logic                     busy_o,
   output logic [$clog2(Depth):0]   level_o,
   output logic                     err_o,
   output logic                     timeout_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned LvlW = PtrW + 1;
   localparam int unsigned AW   = ObiCfg.addr_width;
   localparam logic [LvlW-1:0] FullLvl = LvlW'(Depth);

   localparam logic [2:0] OP_CFG_F1 = 3'd0;
   localparam logic [2:0] OP_CFG_F2 = 3'd1;
   localparam logic [2:0] OP_CFG_CNT = 3'd2;
   localparam logic [2:0] OP_START = 3'd3;
   localparam logic [2:0] OP_WAIT = 3'd4;
   localparam logic [2:0] OP_DELAY = 3'd5;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DELAY} state_t;

   state_t           state_q, state_d;
   logic [2:0]       cmd_op_q, cmd_op_d;
   logic [1:0]       cmd_sel_q, cmd_sel_d;
   logic [31:0]      cmd_data_q, cmd_data_d;
   logic [15:0]      poll_q, poll_d, poll_inc;
   logic [31:0]      dly_q, dly_d;
   logic             flush_pend_q, flush_pend_d;
   logic             err_q, timeout_q, err_set, to_set;

   logic [36:0]      fifo_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LvlW-1:0]  lvl_q;
   logic             full, empty, push, pop;
   logic [36:0]      head;
   logic [7:0]       reg_off;
   logic [AW-1:0]    addr;
   logic             unused_rsp;

   assign full        = (lvl_q == FullLvl);
   assign empty       = (lvl_q == '0);
   assign cmd_ready_o = !full && !flush_i;
   assign push        = cmd_valid_i && cmd_ready_o;
   assign head        = fifo_q[rd_ptr_q];
   assign unused_rsp  = ^{obi_rsp_i.r.rdata[31:1], obi_rsp_i.r.rid};

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= {cmd_op_i, cmd_sel_i, cmd_data_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         lvl_q    <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         lvl_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      lvl_q <= lvl_q + 1'b1;
         else if (pop && !push) lvl_q <= lvl_q - 1'b1;
      end
   end

   assign poll_inc = poll_q + 16'd1;

   always_comb begin
      state_d      = state_q;
      cmd_op_d     = cmd_op_q;
      cmd_sel_d    = cmd_sel_q;
      cmd_data_d   = cmd_data_q;
      poll_d       = poll_q;
      dly_d        = dly_q;
      flush_pend_d = flush_pend_q;
      err_set      = 1'b0;
      to_set       = 1'b0;
      pop          = 1'b0;
      unique case (state_q)
         IDLE: begin
            flush_pend_d = 1'b0;
            if (!empty && !flush_i) begin
               pop        = 1'b1;
               cmd_op_d   = head[36:34];
               cmd_sel_d  = head[33:32];
               cmd_data_d = head[31:0];
               poll_d     = '0;
               dly_d      = head[31:0];
               case (head[36:34])
                  OP_CFG_F1, OP_CFG_F2, OP_CFG_CNT, OP_START, OP_WAIT: state_d = REQ;
                  OP_DELAY: if (head[31:0] != '0) state_d = DELAY;
                  default:  err_set = 1'b1;
               endcase
            end
         end
         REQ: begin
            if (flush_i) flush_pend_d = 1'b1;
            if (obi_rsp_i.gnt) state_d = RESP;
         end
         RESP: begin
            if (flush_i) flush_pend_d = 1'b1;
            if (obi_rsp_i.rvalid) begin
               if (obi_rsp_i.r.err) err_set = 1'b1;
               if (cmd_op_q != OP_WAIT || obi_rsp_i.r.rdata[0]) begin
                  state_d = IDLE;
               end else begin
                  // Saturate so an unlimited poll never wraps back to a matching count.
                  poll_d = (poll_q == '1) ? poll_q : poll_inc;
                  if (cmd_data_q[15:0] != '0 && poll_inc == cmd_data_q[15:0]) begin
                     to_set  = 1'b1;
                     state_d = IDLE;
                  end else if (flush_pend_q || flush_i) begin
                     state_d = IDLE;
                  end else begin
                     state_d = REQ;
                  end
               end
            end
         end
         DELAY: begin
            if (flush_i || dly_q == 32'd1) state_d = IDLE;
            else                           dly_d   = dly_q - 32'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         cmd_op_q     <= '0;
         cmd_sel_q    <= '0;
         cmd_data_q   <= '0;
         poll_q       <= '0;
         dly_q        <= '0;
         flush_pend_q <= 1'b0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_op_q     <= cmd_op_d;
         cmd_sel_q    <= cmd_sel_d;
         cmd_data_q   <= cmd_data_d;
         poll_q       <= poll_d;
         dly_q        <= dly_d;
         flush_pend_q <= flush_pend_d;
         if (err_set)    err_q <= 1'b1;
         else if (clr_i) err_q <= 1'b0;
         if (to_set)     timeout_q <= 1'b1;
         else if (clr_i) timeout_q <= 1'b0;
      end
   end

   always_comb begin
      reg_off = 8'h00;
      case (cmd_op_q)
         OP_CFG_F1:  reg_off = 8'h04;
         OP_CFG_F2:  reg_off = 8'h08;
         OP_CFG_CNT: reg_off = 8'h0C;
         OP_WAIT:    reg_off = 8'h10;
         default:    reg_off = 8'h00;
      endcase
   end

   // START is a wrapper-global register, so the pulser select is ignored.
   assign addr = (cmd_op_q == OP_START) ? BaseAddr[AW-1:0]
               : BaseAddr[AW-1:0] | AW'({1'b0, cmd_sel_q, 5'b0}) | AW'(reg_off);

   always_comb begin
      obi_req_o = '0;
      if (state_q == REQ) begin
         obi_req_o.req     = 1'b1;
         obi_req_o.a.addr  = addr;
         obi_req_o.a.we    = (cmd_op_q != OP_WAIT);
         obi_req_o.a.be    = 4'hF;
         obi_req_o.a.aid   = '0;
         if (cmd_op_q == OP_START)     obi_req_o.a.wdata = {24'b0, cmd_data_q[7:0]};
         else if (cmd_op_q != OP_WAIT) obi_req_o.a.wdata = cmd_data_q;
      end
   end

   assign busy_o    = (state_q != IDLE) || !empty;
   assign level_o   = lvl_q;
   assign err_o     = err_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_user_pulse_sequencer.sv
// Directed bench for user_pulse_sequencer with a one-cycle-latency OBI
// responder model, a transaction monitor and hand-computed expectations.

module tb_user_pulse_sequencer;

   localparam logic [31:0] B = 32'h2000_0300;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [1:0]  cmd_sel = '0;
   logic [31:0] cmd_data = '0;
   logic        flush = 1'b0;
   logic        clr = 1'b0;
   logic        busy, err, timeout;
   logic [2:0]  level;
   user_pulse_sequencer_pkg::obi_req_t obi_req;
   user_pulse_sequencer_pkg::obi_rsp_t obi_rsp;

   user_pulse_sequencer #(.BaseAddr(B), .Depth(4)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_sel_i(cmd_sel), .cmd_data_i(cmd_data),
      .flush_i(flush), .clr_i(clr),
      .obi_req_o(obi_req), .obi_rsp_i(obi_rsp),
      .busy_o(busy), .level_o(level), .err_o(err), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   // responder model
   logic        gnt_en = 1'b1, never_ready = 1'b0, err_inj = 1'b0;
   int          busy_until = 0;
   int          cyc = 0;
   logic        gnt;
   logic        rvalid_q = 1'b0, rerr_q = 1'b0;
   logic [31:0] rdata_q = '0;
   logic        ready_now;

   assign gnt       = obi_req.req && gnt_en;
   assign ready_now = !never_ready && (cyc >= busy_until);

   always_comb begin
      obi_rsp          = '0;
      obi_rsp.gnt      = gnt;
      obi_rsp.rvalid   = rvalid_q;
      obi_rsp.r.rdata  = rdata_q;
      obi_rsp.r.err    = rerr_q;
   end

   // monitor
   int          txn_cnt = 0, rd_cnt = 0, rdy_rsp_cnt = 0, proto_err = 0, stab_err = 0;
   int          last_gnt_cyc = 0, prev_gnt_cyc = 0;
   logic        outstanding = 1'b0, held_valid = 1'b0;
   logic [31:0] held_addr = '0, held_wdata = '0, last_addr = '0, last_wdata = '0;
   logic        last_we = 1'b0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rvalid_q <= obi_req.req && gnt;
      rdata_q  <= {31'b0, ready_now};
      rerr_q   <= err_inj;
      if (obi_req.req && outstanding) proto_err <= proto_err + 1;
      if (obi_req.req && gnt) begin
         outstanding  <= 1'b1;
         txn_cnt      <= txn_cnt + 1;
         if (!obi_req.a.we) rd_cnt <= rd_cnt + 1;
         last_addr    <= obi_req.a.addr;
         last_wdata   <= obi_req.a.wdata;
         last_we      <= obi_req.a.we;
         prev_gnt_cyc <= last_gnt_cyc;
         last_gnt_cyc <= cyc;
      end else if (rvalid_q) begin
         outstanding <= 1'b0;
      end
      if (rvalid_q && rdata_q[0]) rdy_rsp_cnt <= rdy_rsp_cnt + 1;
      if (obi_req.req) begin
         if (held_valid && (obi_req.a.addr != held_addr || obi_req.a.wdata != held_wdata))
            stab_err <= stab_err + 1;
         held_valid <= !gnt;
         held_addr  <= obi_req.a.addr;
         held_wdata <= obi_req.a.wdata;
      end else begin
         held_valid <= 1'b0;
      end
   end

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] op, input logic [1:0] sel, input logic [31:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_sel   = sel;
      cmd_data  = data;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'b0, busy}, 32'd0);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  sel;
      logic [31:0] data;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic        exp_we;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, r0, y0;
      vecs[0] = '{3'd0, 2'd2, 32'h0010_0008, B | 32'h44, 32'h0010_0008, 1'b1};
      vecs[1] = '{3'd1, 2'd0, 32'hDEAD_BEEF, B | 32'h08, 32'hDEAD_BEEF, 1'b1};
      vecs[2] = '{3'd2, 2'd3, 32'h0000_1234, B | 32'h6C, 32'h0000_1234, 1'b1};
      vecs[3] = '{3'd3, 2'd1, 32'h0000_0005, B,          32'h0000_0005, 1'b1};
      vecs[4] = '{3'd3, 2'd3, 32'hFFFF_FFA5, B,          32'h0000_00A5, 1'b1};
      vecs[5] = '{3'd1, 2'd3, 32'h0000_0000, B | 32'h68, 32'h0000_0000, 1'b1};

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_req", {31'b0, obi_req.req}, 0);
      chk("rst_addr", obi_req.a.addr, 0);
      chk("rst_wdata", obi_req.a.wdata, 0);
      chk("rst_we", {31'b0, obi_req.a.we}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_level", {29'b0, level}, 0);
      chk("rst_err_to", {30'b0, err, timeout}, 0);
      chk("rst_ready", {31'b0, cmd_ready}, 1);
      rst_ni = 1'b1;
      @(negedge clk);

      // single write latency: CFG_F1 sel=2
      push(3'd0, 2'd2, 32'h0010_0008);
      chk("lat_level_after_push", {29'b0, level}, 1);
      chk("lat_req_c1", {31'b0, obi_req.req}, 0);
      @(negedge clk);
      chk("lat_req_c2", {31'b0, obi_req.req}, 1);
      chk("lat_addr", obi_req.a.addr, B | 32'h44);
      chk("lat_wdata", obi_req.a.wdata, 32'h0010_0008);
      @(negedge clk);
      chk("lat_req_c3", {31'b0, obi_req.req}, 0);
      chk("lat_busy_c3", {31'b0, busy}, 1);
      @(negedge clk);
      chk("lat_busy_c4", {31'b0, busy}, 0);

      // table-driven writes
      for (int i = 0; i < 6; i++) begin
         t0 = txn_cnt;
         push(vecs[i].op, vecs[i].sel, vecs[i].data);
         wait_idle(20, $sformatf("vec%0d_idle", i));
         chk($sformatf("vec%0d_txns", i), txn_cnt - t0, 1);
         chk($sformatf("vec%0d_addr", i), last_addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
         chk($sformatf("vec%0d_we", i), {31'b0, last_we}, {31'b0, vecs[i].exp_we});
      end

      // back-to-back writes: one request every third cycle
      push(3'd0, 2'd0, 32'h1);
      push(3'd1, 2'd1, 32'h2);
      wait_idle(20, "b2b_idle");
      chk("b2b_gap", last_gnt_cyc - prev_gnt_cyc, 3);

      // DELAY 5 between writes, then DELAY 0
      push(3'd0, 2'd0, 32'h3);
      push(3'd5, 2'd0, 32'd5);
      push(3'd0, 2'd0, 32'h4);
      wait_idle(40, "dly5_idle");
      chk("dly5_gap", last_gnt_cyc - prev_gnt_cyc, 9);
      push(3'd0, 2'd0, 32'h5);
      push(3'd5, 2'd0, 32'd0);
      push(3'd0, 2'd0, 32'h6);
      wait_idle(40, "dly0_idle");
      chk("dly0_gap", last_gnt_cyc - prev_gnt_cyc, 4);

      // WAIT_READY unlimited on a pulser busy for 20 cycles
      t0 = txn_cnt; r0 = rd_cnt; y0 = rdy_rsp_cnt;
      busy_until = cyc + 20;
      push(3'd4, 2'd1, 32'd0);
      wait_idle(200, "wait_unl_idle");
      chk("wait_unl_multi_reads", {31'b0, (rd_cnt - r0) >= 2}, 1);
      chk("wait_unl_all_reads", txn_cnt - t0, rd_cnt - r0);
      chk("wait_unl_one_ready", rdy_rsp_cnt - y0, 1);
      chk("wait_unl_addr", last_addr, B | 32'h30);
      chk("wait_unl_timeout", {31'b0, timeout}, 0);

      // WAIT_READY limit 3 on a never-ready pulser, then a following write
      never_ready = 1'b1;
      t0 = txn_cnt; r0 = rd_cnt;
      push(3'd4, 2'd0, 32'd3);
      push(3'd0, 2'd1, 32'h77);
      wait_idle(100, "wait_lim_idle");
      chk("wait_lim_reads", rd_cnt - r0, 3);
      chk("wait_lim_txns", txn_cnt - t0, 4);
      chk("wait_lim_timeout", {31'b0, timeout}, 1);
      chk("wait_lim_next_addr", last_addr, B | 32'h24);
      chk("wait_lim_next_wdata", last_wdata, 32'h77);
      pulse_clr();
      chk("wait_lim_clr", {31'b0, timeout}, 0);

      // flush during an unlimited poll: finish in-flight read, no more polls
      push(3'd4, 2'd2, 32'd0);
      repeat (7) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_idle(10, "poll_flush_idle");
      r0 = rd_cnt;
      repeat (10) @(negedge clk);
      chk("poll_flush_no_more", rd_cnt - r0, 0);
      chk("poll_flush_outstanding", {31'b0, outstanding}, 0);
      chk("poll_flush_timeout", {31'b0, timeout}, 0);
      never_ready = 1'b0;

      // fill FIFO behind a long DELAY, then flush with a dropped push
      t0 = txn_cnt;
      for (int i = 0; i < 5; i++) push(3'd5, 2'd0, 32'd100);
      chk("full_level", {29'b0, level}, 4);
      chk("full_ready", {31'b0, cmd_ready}, 0);
      chk("full_busy", {31'b0, busy}, 1);
      flush = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = 3'd0;
      #1;
      chk("flush_ready", {31'b0, cmd_ready}, 0);
      @(negedge clk);
      flush = 1'b0;
      cmd_valid = 1'b0;
      chk("flush_level", {29'b0, level}, 0);
      chk("flush_busy", {31'b0, busy}, 0);
      repeat (3) @(negedge clk);
      chk("flush_no_txn", txn_cnt - t0, 0);

      // reserved opcode, then a CFG_CNT stalled 5 cycles by gnt low
      t0 = txn_cnt;
      push(3'd6, 2'd0, 32'd0);
      wait_idle(10, "rsvd_idle");
      chk("rsvd_err", {31'b0, err}, 1);
      chk("rsvd_no_txn", txn_cnt - t0, 0);
      gnt_en = 1'b0;
      push(3'd2, 2'd1, 32'h0000_ABCD);
      repeat (6) @(negedge clk);
      chk("stall_req_held", {31'b0, obi_req.req}, 1);
      gnt_en = 1'b1;
      wait_idle(10, "stall_idle");
      chk("stall_txns", txn_cnt - t0, 1);
      chk("stall_addr", last_addr, B | 32'h2C);
      chk("stall_wdata", last_wdata, 32'h0000_ABCD);
      chk("stall_stable", stab_err, 0);
      pulse_clr();
      chk("rsvd_clr", {31'b0, err}, 0);

      // response error while clr_i is held high: set wins
      clr = 1'b1;
      err_inj = 1'b1;
      push(3'd1, 2'd0, 32'h1);
      wait_idle(20, "rerr_idle");
      chk("rerr_set_wins", {31'b0, err}, 1);
      clr = 1'b0;
      err_inj = 1'b0;
      @(negedge clk);
      chk("rerr_sticky", {31'b0, err}, 1);
      pulse_clr();
      chk("rerr_clr", {31'b0, err}, 0);

      chk("protocol_one_outstanding", proto_err, 0);

      // async reset mid-request drops req at once
      gnt_en = 1'b0;
      push(3'd0, 2'd3, 32'h9);
      @(negedge clk);
      chk("arst_req_before", {31'b0, obi_req.req}, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_req_dropped", {31'b0, obi_req.req}, 0);
      chk("arst_busy", {31'b0, busy}, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      gnt_en = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
